oam_scanner: RTL and testbench

//  PPU mode-2 stage directly upstream of the sprite fetcher. Walks all 40 OAM entries once per line.

---
 rtl/oam_scanner.sv | 146 ++++++++++++++
 tb/tb_oam_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_scanner.sv
// Mode-2 OAM scanner: walks every OAM entry once per line and packs up to MAX_SPRITES
// objects covering the current line as {X, obj_num, row} for the sprite fetcher.
module oam_scanner #(
  parameter int          NUM_OBJ     = 40,
  parameter int          MAX_SPRITES = 10,
  parameter logic [15:0] OAM_BASE    = 16'hFE00
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         tclk_in,
  input  logic                         start_in,
  input  logic [7:0]                   ly_in,
  input  logic                         tall_sprite_mode_in,
  output logic [15:0]                  oam_addr_out,
  output logic                         oam_req_out,
  input  logic [7:0]                   oam_data_in,
  input  logic                         oam_valid_in,
  output logic [MAX_SPRITES-1:0][17:0] sprite_buffer_out,
  output logic [3:0]                   sprite_count_out,
  output logic                         busy_out,
  output logic                         done_out
);

  typedef enum logic [1:0] {IDLE, FETCH_Y, FETCH_X, FINISH} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] obj_n;
  logic [7:0] ly_q;
  logic [7:0] y_q;
  logic [7:0] x_q;
  logic       pend_q;
  logic       go;
  logic       eval_en;
  logic       addr_load;
  logic       fin;
  logic       last_obj;
  logic       cap_ok;
  logic [7:0] rd_byte;
  logic [5:0] eval_num;
  logic [4:0] eval_res;

  // Returns {hit, row}; bit 8 of the 9-bit difference flags an object below the line.
  function automatic logic [4:0] eval_obj(input logic [7:0] ly, input logic [7:0] y,
                                          input logic tall);
    logic [8:0] d;
    logic [8:0] h;
    d = {1'b0, ly} + 9'd16 - {1'b0, y};
    h = tall ? 9'd16 : 9'd8;
    return {(!d[8] && (d < h)), d[3:0]};
  endfunction

  assign rd_byte  = oam_valid_in ? oam_data_in : 8'hFF;
  assign last_obj = (obj_n == 6'(NUM_OBJ - 1));
  // FETCH_Y scores the previous entry; FINISH scores the last entry without advancing obj_n.
  assign eval_num = (state == FINISH) ? obj_n : obj_n - 6'd1;
  assign eval_res = eval_obj(ly_q, y_q, tall_sprite_mode_in);
  assign cap_ok   = (sprite_count_out < 4'(MAX_SPRITES));

  always_comb begin
    go = 1'b0;
    if (tclk_in) begin
      case (state)
        IDLE:             go = start_in || pend_q;
        FETCH_Y, FETCH_X: go = start_in;
        default:          go = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (go) begin
      state_nxt = FETCH_Y;
    end else if (tclk_in) begin
      case (state)
        FETCH_Y: state_nxt = FETCH_X;
        FETCH_X: state_nxt = last_obj ? FINISH : FETCH_Y;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_out  = (state != IDLE);
    fin       = tclk_in && (state == FINISH);
    eval_en   = tclk_in && !go && ((state == FETCH_Y && obj_n != 6'd0) || state == FINISH);
    addr_load = go || (tclk_in && (state == FETCH_Y || (state == FETCH_X && !last_obj)));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      oam_addr_out      <= '0;
      oam_req_out       <= 1'b0;
      done_out          <= 1'b0;
      sprite_buffer_out <= '0;
      sprite_count_out  <= '0;
      obj_n             <= '0;
      ly_q              <= '0;
      y_q               <= '0;
      x_q               <= '0;
      pend_q            <= 1'b0;
    end else begin
      oam_req_out <= addr_load;
      done_out    <= fin;
      if (tclk_in) begin
        // A start landing on FINISH is held over so the new scan begins from IDLE.
        if (state == FINISH) pend_q <= start_in;
        else if (go)         pend_q <= 1'b0;
        if (go) begin
          ly_q              <= ly_in;
          obj_n             <= '0;
          sprite_buffer_out <= '0;
          sprite_count_out  <= '0;
          oam_addr_out      <= OAM_BASE;
        end else begin
          case (state)
            FETCH_Y: begin
              y_q          <= rd_byte;
              oam_addr_out <= OAM_BASE + {8'd0, obj_n, 2'b01};
            end
            FETCH_X: begin
              x_q <= rd_byte;
              if (!last_obj) begin
                obj_n        <= obj_n + 6'd1;
                oam_addr_out <= OAM_BASE + {8'd0, obj_n + 6'd1, 2'b00};
              end
            end
            default: ;
          endcase
          if (eval_en && eval_res[4] && cap_ok) begin
            sprite_buffer_out[sprite_count_out] <= {x_q, eval_num, eval_res[3:0]};
            sprite_count_out                    <= sprite_count_out + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_scanner.sv
// Bench for oam_scanner: directed vector table, hand-written restart/reset sequences and
// randomized OAM contents checked against a list-based selection model.
module tb_oam_scanner;
  localparam int          NOBJ = 40;
  localparam int          MAXS = 10;
  localparam logic [15:0] BASE = 16'hFE00;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  tclk_in;
  logic                  start_in;
  logic [7:0]            ly_in;
  logic                  tall_sprite_mode_in;
  logic [15:0]           oam_addr_out;
  logic                  oam_req_out;
  logic [7:0]            oam_data_in;
  logic                  oam_valid_in;
  logic [MAXS-1:0][17:0] sprite_buffer_out;
  logic [3:0]            sprite_count_out;
  logic                  busy_out;
  logic                  done_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem  [160];
  logic        vmem [160];
  logic [17:0] exp_slot [MAXS];
  int          exp_cnt;

  typedef struct {
    logic [7:0]  ly;
    logic        tall;
    logic        fill_all;
    int          idx;
    logic [7:0]  y;
    logic [7:0]  x;
    int          ecnt;
    logic [17:0] eslot0;
  } vec_t;
  vec_t tbl [4];

  always #5 clk_in = ~clk_in;

  oam_scanner dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .tclk_in             (tclk_in),
    .start_in            (start_in),
    .ly_in               (ly_in),
    .tall_sprite_mode_in (tall_sprite_mode_in),
    .oam_addr_out        (oam_addr_out),
    .oam_req_out         (oam_req_out),
    .oam_data_in         (oam_data_in),
    .oam_valid_in        (oam_valid_in),
    .sprite_buffer_out   (sprite_buffer_out),
    .sprite_count_out    (sprite_count_out),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present the byte at the current address, then strobe tclk for one clk.
  task automatic tick(input logic st);
    int idx;
    idx = int'(oam_addr_out) - int'(BASE);
    if (idx >= 0 && idx < 160) begin
      oam_data_in  = mem[idx];
      oam_valid_in = vmem[idx];
    end else begin
      oam_data_in  = 8'h00;
      oam_valid_in = 1'b1;
    end
    start_in = st;
    tclk_in  = 1'b1;
    @(posedge clk_in); #1;
    tclk_in  = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic step(input logic st, input logic exp_req, input logic exp_done, input string tag);
    tick(st);
    chk({tag, "_req"}, 32'(oam_req_out), 32'(exp_req));
    chk({tag, "_done"}, 32'(done_out), 32'(exp_done));
    @(posedge clk_in); #1;
    chk({tag, "_req_clr"}, 32'(oam_req_out), 32'd0);
    chk({tag, "_done_clr"}, 32'(done_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  // Selection model: scan entries in order, keep the first MAXS covering the line.
  task automatic model(input logic [7:0] ly, input logic tall);
    int d;
    int h;
    logic [7:0] y;
    logic [7:0] x;
    exp_cnt = 0;
    for (int i = 0; i < MAXS; i++) exp_slot[i] = '0;
    h = tall ? 16 : 8;
    for (int n = 0; n < NOBJ; n++) begin
      y = vmem[4*n]   ? mem[4*n]   : 8'hFF;
      x = vmem[4*n+1] ? mem[4*n+1] : 8'hFF;
      d = int'(ly) + 16 - int'(y);
      if (d >= 0 && d < h && exp_cnt < MAXS) begin
        exp_slot[exp_cnt] = {x, 6'(n), 4'(d)};
        exp_cnt++;
      end
    end
  endtask

  task automatic scan(input logic [7:0] ly, input logic tall, input logic st0,
                      input logic st_fin, input string tag);
    logic [15:0] ea;
    ly_in = ly;
    tall_sprite_mode_in = tall;
    step(st0, 1'b1, 1'b0, {tag, "_t0"});
    chk({tag, "_t0_addr"}, 32'(oam_addr_out), 32'(BASE));
    chk({tag, "_t0_busy"}, 32'(busy_out), 32'd1);
    chk({tag, "_t0_cnt"}, 32'(sprite_count_out), 32'd0);
    chk({tag, "_t0_slot0"}, 32'(sprite_buffer_out[0]), 32'd0);
    ly_in = ~ly;
    for (int k = 1; k <= 80; k++) begin
      if (k % 2 == 1)  ea = BASE + 16'(4 * ((k - 1) / 2) + 1);
      else if (k < 80) ea = BASE + 16'(4 * (k / 2));
      else             ea = BASE + 16'h009D;
      step(1'b0, k < 80, 1'b0, $sformatf("%s_t%0d", tag, k));
      chk($sformatf("%s_addr%0d", tag, k), 32'(oam_addr_out), 32'(ea));
    end
    step(st_fin, 1'b0, 1'b1, {tag, "_t81"});
    chk({tag, "_end_busy"}, 32'(busy_out), 32'd0);
    model(ly, tall);
    chk({tag, "_cnt"}, 32'(sprite_count_out), 32'(exp_cnt));
    for (int i = 0; i < MAXS; i++)
      chk($sformatf("%s_slot%0d", tag, i), 32'(sprite_buffer_out[i]), 32'(exp_slot[i]));
  endtask

  task automatic fill_bg();
    for (int i = 0; i < 160; i++) begin
      mem[i]  = 8'($urandom);
      vmem[i] = 1'b1;
    end
    for (int n = 0; n < NOBJ; n++) begin
      mem[4*n]   = 8'h00;
      mem[4*n+1] = 8'h00;
    end
  endtask

  logic [7:0] rl;
  logic       rt;

  initial begin
    tbl[0] = '{ly:8'd0,  tall:1'b0, fill_all:1'b0, idx:0, y:8'd16, x:8'd20, ecnt:1,  eslot0:18'h05000};
    tbl[1] = '{ly:8'd12, tall:1'b0, fill_all:1'b0, idx:5, y:8'd16, x:8'd33, ecnt:0,  eslot0:18'h00000};
    tbl[2] = '{ly:8'd12, tall:1'b1, fill_all:1'b0, idx:5, y:8'd16, x:8'd33, ecnt:1,  eslot0:18'h0845C};
    tbl[3] = '{ly:8'd3,  tall:1'b0, fill_all:1'b1, idx:0, y:8'd16, x:8'd7,  ecnt:10, eslot0:18'h01C03};

    rst_in = 1'b1; tclk_in = 1'b0; start_in = 1'b0; ly_in = '0;
    tall_sprite_mode_in = 1'b0; oam_data_in = '0; oam_valid_in = 1'b0;
    fill_bg();
    #12;
    chk("rst_addr", 32'(oam_addr_out), 32'd0);
    chk("rst_req", 32'(oam_req_out), 32'd0);
    chk("rst_cnt", 32'(sprite_count_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_buf", 32'(sprite_buffer_out != '0), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;

    foreach (tbl[i]) begin
      fill_bg();
      if (tbl[i].fill_all) begin
        for (int n = 0; n < NOBJ; n++) begin
          mem[4*n]   = tbl[i].y;
          mem[4*n+1] = tbl[i].x;
        end
      end else begin
        mem[4*tbl[i].idx]   = tbl[i].y;
        mem[4*tbl[i].idx+1] = tbl[i].x;
      end
      scan(tbl[i].ly, tbl[i].tall, 1'b1, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ecnt", i), 32'(sprite_count_out), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_eslot0", i), 32'(sprite_buffer_out[0]), 32'(tbl[i].eslot0));
    end
    chk("cap_slot9", 32'(sprite_buffer_out[9]), 32'h01C93);

    // Every read invalid: all bytes are FF, nothing selected.
    for (int i = 0; i < 160; i++) begin
      mem[i]  = 8'($urandom);
      vmem[i] = 1'b0;
    end
    scan(8'd0, 1'b0, 1'b1, 1'b0, "inval");
    chk("inval_cnt", 32'(sprite_count_out), 32'd0);
    chk("inval_buf", 32'(sprite_buffer_out != '0), 32'd0);

    // Restart at T-cycle 30 with a different line.
    fill_bg();
    for (int n = 0; n < 6; n++) begin mem[4*n] = 8'd36; mem[4*n+1] = 8'd50; end
    for (int n = 10; n < 13; n++) begin mem[4*n] = 8'd116; mem[4*n+1] = 8'(60 + n); end
    ly_in = 8'd20; tall_sprite_mode_in = 1'b0;
    step(1'b1, 1'b1, 1'b0, "rs_t0");
    for (int k = 1; k < 30; k++) step(1'b0, 1'b1, 1'b0, $sformatf("rs_t%0d", k));
    chk("rs_cnt_before", 32'(sprite_count_out), 32'd6);
    scan(8'd100, 1'b0, 1'b1, 1'b0, "rs2");
    chk("rs2_fixed_cnt", 32'(sprite_count_out), 32'd3);

    // Asynchronous reset between strobes, mid-scan.
    ly_in = 8'd20;
    step(1'b1, 1'b1, 1'b0, "ar_t0");
    for (int k = 1; k <= 40; k++) step(1'b0, 1'b1, 1'b0, $sformatf("ar_t%0d", k));
    chk("ar_cnt_before", 32'(sprite_count_out), 32'd6);
    #2 rst_in = 1'b1;
    #1;
    chk("ar_busy", 32'(busy_out), 32'd0);
    chk("ar_addr", 32'(oam_addr_out), 32'd0);
    chk("ar_cnt", 32'(sprite_count_out), 32'd0);
    chk("ar_buf", 32'(sprite_buffer_out != '0), 32'd0);
    chk("ar_req", 32'(oam_req_out), 32'd0);
    chk("ar_done", 32'(done_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, $sformatf("ar_idle%0d", k));
    chk("ar_idle_busy", 32'(busy_out), 32'd0);
    scan(8'd20, 1'b0, 1'b1, 1'b0, "ar_clean");
    chk("ar_clean_cnt", 32'(sprite_count_out), 32'd6);

    // Start on the FINISH strobe: done fires, then the held start begins a new scan.
    fill_bg();
    mem[12] = 8'd16; mem[13] = 8'd9;
    scan(8'd5, 1'b0, 1'b1, 1'b1, "pf1");
    scan(8'd5, 1'b0, 1'b0, 1'b0, "pf2");
    chk("pf2_slot0", 32'(sprite_buffer_out[0]), 32'({8'd9, 6'd3, 4'd5}));

    for (int it = 0; it < 6; it++) begin
      rl = 8'($urandom_range(0, 150));
      rt = 1'($urandom_range(0, 1));
      for (int i = 0; i < 160; i++) begin
        mem[i]  = 8'($urandom);
        vmem[i] = ($urandom_range(0, 15) != 0);
      end
      for (int n = 0; n < NOBJ; n++)
        if ($urandom_range(0, 3) != 0)
          mem[4*n] = 8'(int'(rl) + 16 - int'($urandom_range(0, (it % 2 == 0) ? 20 : 60)));
      scan(rl, rt, 1'b1, 1'b0, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
